// File: rtl/vm_pkg.sv
// Coin codes shared between the coin acceptor front-end and the vending FSM.
package vm_pkg;

    typedef logic [1:0] coin_t;

    localparam coin_t COIN_NONE   = 2'b00;
    localparam coin_t COIN_NICKEL = 2'b01;
    localparam coin_t COIN_DIME   = 2'b10;

    // Code for a single qualified event; callers guarantee at most one is set.
    function automatic coin_t event_code(input logic nick_ev);
        return nick_ev ? COIN_NICKEL : COIN_DIME;
    endfunction

endpackage

// File: rtl/coin_debounce.sv
// One coin-sensor channel: two-flop synchronizer, debounce counter,
// debounced level and a registered one-cycle rising-edge pulse.
module coin_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic rise
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stable_q, stable_d;
    logic             rise_q, rise_d;

    always_comb begin
        sync1_d  = raw;
        sync2_d  = sync1_q;
        cnt_d    = '0;
        stable_d = stable_q;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        // Edge is registered together with the level flip, so it lasts one cycle.
        rise_d = stable_d & ~stable_q;
    end

    // Stable resets high: a sensor held through reset must first debounce low.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            cnt_q    <= '0;
            stable_q <= 1'b1;
            rise_q   <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            rise_q   <= rise_d;
        end
    end

    assign rise = rise_q;

endmodule

// File: rtl/coin_acceptor.sv
// Vending-machine front end: debounces both coin sensors, buffers qualified
// coins in a small FIFO and presents them as one-cycle codes on coin.
module coin_acceptor
    import vm_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          nickel_raw,
    input  logic                          dime_raw,
    input  logic                          accept_en,
    output logic [1:0]                    coin,
    output logic                          reject,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int PTR_W = AW + 1;

    logic nick_ev;
    logic dime_ev;

    coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_nickel (
        .clk   (clk),
        .reset (reset),
        .raw   (nickel_raw),
        .rise  (nick_ev)
    );

    coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dime (
        .clk   (clk),
        .reset (reset),
        .raw   (dime_raw),
        .rise  (dime_ev)
    );

    coin_t             mem_q [FIFO_DEPTH];
    coin_t             mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    coin_t             coin_q, coin_d;
    logic              reject_q, reject_d;

    logic [PTR_W-1:0]  count;
    logic              empty;
    logic              full;
    logic              pop;
    logic              push;
    logic              jam;
    logic              single;

    always_comb begin
        count  = wr_ptr_q - rd_ptr_q;
        empty  = (count == '0);
        full   = (count == PTR_W'(FIFO_DEPTH));
        pop    = ~empty & accept_en;
        jam    = nick_ev & dime_ev;
        single = nick_ev ^ dime_ev;
        // A pop in the same cycle frees the slot, so a full FIFO can still take the coin.
        push   = single & (~full | pop);

        reject_d = jam | (single & full & ~pop);
        coin_d   = pop ? mem_q[rd_ptr_q[AW-1:0]] : COIN_NONE;
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);

        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q[AW-1:0]] = event_code(nick_ev);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            coin_q   <= COIN_NONE;
            reject_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            coin_q   <= coin_d;
            reject_q <= reject_d;
        end
    end

    // Storage is never read before it is written, so it carries no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign coin       = coin_q;
    assign reject     = reject_q;
    assign fifo_count = count;

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor, including a tiny vending-FSM model driving accept_en.
module tb_coin_acceptor;

    localparam int DC = 4;
    localparam int FD = 4;
    localparam int CW = $clog2(FD) + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          nickel_raw = 1'b0;
    logic          dime_raw = 1'b0;
    logic          accept_en;
    logic          accept_drv = 1'b1;
    logic          fsm_mode = 1'b0;
    logic          news = 1'b0;
    logic [1:0]    coin;
    logic          reject;
    logic [CW-1:0] fifo_count;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int n_nick, n_dime, n_rej, n_news, news_viol, first_cyc, last_cyc;
    int n_bad = 0;
    int total = 0;
    int r;
    logic [1:0] last_code;

    assign accept_en = fsm_mode ? ~news : accept_drv;

    always #5 clk = ~clk;

    coin_acceptor #(.DEBOUNCE_CYCLES(DC), .FIFO_DEPTH(FD)) dut (
        .clk        (clk),
        .reset      (reset),
        .nickel_raw (nickel_raw),
        .dime_raw   (dime_raw),
        .accept_en  (accept_en),
        .coin       (coin),
        .reject     (reject),
        .fifo_count (fifo_count)
    );

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int coin_val(input logic [1:0] c);
        return (c == 2'b01) ? 5 : (c == 2'b10) ? 10 : 0;
    endfunction

    // Minimal vending FSM: news pulses one cycle once 15 units are collected.
    always @(posedge clk) begin
        if (reset || !fsm_mode) begin
            news  <= 1'b0;
            total <= 0;
        end else if (news) begin
            news <= 1'b0;
        end else if (total + coin_val(coin) >= 15) begin
            news  <= 1'b1;
            total <= 0;
        end else begin
            total <= total + coin_val(coin);
        end
    end

    always @(negedge clk) begin
        if (coin == 2'b01) n_nick++;
        if (coin == 2'b10) n_dime++;
        if (coin == 2'b11) n_bad++;
        if (coin != 2'b00) begin
            if (first_cyc < 0) first_cyc = cyc;
            last_cyc  = cyc;
            last_code = coin;
        end
        if (reject) n_rej++;
        if (news) begin
            n_news++;
            if (coin != 2'b00) news_viol++;
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clr();
        n_nick = 0; n_dime = 0; n_rej = 0; n_news = 0; news_viol = 0;
        first_cyc = -1; last_cyc = -1; last_code = 2'b00;
    endtask

    task automatic insert_dime();
        dime_raw = 1'b1;
        step(6);
        dime_raw = 1'b0;
        step(6);
    endtask

    initial begin
        clr();
        reset = 1'b1;
        step(3);
        reset = 1'b0;
        @(negedge clk);
        check("rst_coin", coin, 0);
        check("rst_reject", reject, 0);
        check("rst_count", fifo_count, 0);

        // Single nickel: latency 8 edges from the raw rise
        step(8);
        clr();
        r = cyc;
        nickel_raw = 1'b1;
        step(10);
        nickel_raw = 1'b0;
        step(20);
        check("nick_count", n_nick, 1);
        check("nick_latency", first_cyc - r, 8);
        check("nick_code", last_code, 1);
        check("nick_fifo", fifo_count, 0);
        check("nick_reject", n_rej, 0);

        // Short glitch on the dime line
        clr();
        dime_raw = 1'b1;
        step(2);
        dime_raw = 1'b0;
        step(20);
        check("glitch_dime", n_dime, 0);
        check("glitch_nick", n_nick, 0);

        // Dime held high through reset
        clr();
        dime_raw = 1'b1;
        reset = 1'b1;
        step(3);
        reset = 1'b0;
        step(20);
        check("rsthigh_dime", n_dime, 0);
        check("rsthigh_reject", n_rej, 0);
        dime_raw = 1'b0;
        step(12);
        check("rsthigh_fall", n_dime, 0);

        // Jam: both lines together
        clr();
        nickel_raw = 1'b1;
        dime_raw = 1'b1;
        step(10);
        nickel_raw = 1'b0;
        dime_raw = 1'b0;
        step(20);
        check("jam_nick", n_nick, 0);
        check("jam_dime", n_dime, 0);
        check("jam_reject", n_rej, 1);
        check("jam_fifo", fifo_count, 0);

        // Stall and overflow
        clr();
        accept_drv = 1'b0;
        for (int i = 0; i < 5; i++) insert_dime();
        step(10);
        check("ovf_count", fifo_count, 4);
        check("ovf_reject", n_rej, 1);
        check("ovf_nocoin", n_dime, 0);
        clr();
        accept_drv = 1'b1;
        step(10);
        check("drain_dimes", n_dime, 4);
        check("drain_b2b", last_cyc - first_cyc, 3);
        check("drain_fifo", fifo_count, 0);
        check("drain_reject", n_rej, 0);

        // Push and pop on the same cycle with a full FIFO
        clr();
        accept_drv = 1'b0;
        for (int i = 0; i < 4; i++) insert_dime();
        step(10);
        check("pp_full", fifo_count, 4);
        clr();
        nickel_raw = 1'b1;
        step(6);
        accept_drv = 1'b1;
        step(1);
        accept_drv = 1'b0;
        @(negedge clk);
        check("pp_count", fifo_count, 4);
        check("pp_coin", coin, 2);
        step(3);
        nickel_raw = 1'b0;
        step(10);
        check("pp_hold", fifo_count, 4);
        check("pp_reject", n_rej, 0);

        // Reset with a full buffer
        reset = 1'b1;
        accept_drv = 1'b1;
        step(1);
        reset = 1'b0;
        @(negedge clk);
        check("midrst_coin", coin, 0);
        check("midrst_reject", reject, 0);
        check("midrst_fifo", fifo_count, 0);
        clr();
        step(12);
        check("midrst_quiet", n_nick + n_dime + n_rej, 0);

        // Drive three nickels through the FSM model
        clr();
        fsm_mode = 1'b1;
        for (int i = 0; i < 3; i++) begin
            nickel_raw = 1'b1;
            step(6);
            nickel_raw = 1'b0;
            step(6);
        end
        step(15);
        check("fsm_nickels", n_nick, 3);
        check("fsm_news", n_news, 1);
        check("fsm_news_coin", news_viol, 0);
        check("fsm_fifo", fifo_count, 0);
        fsm_mode = 1'b0;

        check("bad_code", n_bad, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
